// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the RV32I funct3 size/sign codes, the FSM state encoding, the default
// data-memory word-address width and a helper that classifies an op as faulting.
package lsu_pkg;

    localparam int LSU_ADDR_W = 10;

    // funct3 codes (loads use all five, stores use the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // Illegal size code or an access not aligned to its natural size.
    function automatic logic op_fault(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (funct3 > F3_W);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
// Ports:
//   i_funct3   - size/sign code of the op in flight
//   i_addr_lo  - byte offset within the word
//   i_rd_word  - word currently returned by data memory (load path)
//   i_rmw_word - word captured during the read half of a sub-word store
//   i_st_data  - right-aligned store source
//   o_load_val - selected byte/half/word, sign- or zero-extended
//   o_wr_word  - word to write back (full word for SW, merged lane for SB/SH)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_rmw_word,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_load_val,
    output logic [31:0] o_wr_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: pick the addressed lane and extend it to 32 bits.
    always_comb begin
        w_byte     = i_rd_word[{i_addr_lo, 3'b000} +: 8];
        w_half     = i_rd_word[{i_addr_lo[1], 4'b0000} +: 16];
        o_load_val = 32'h0000_0000;
        case (i_funct3)
            F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_val = i_rd_word;
            F3_BU:   o_load_val = {24'h00_0000, w_byte};
            F3_HU:   o_load_val = {16'h0000, w_half};
            default: o_load_val = 32'h0000_0000;
        endcase
    end

    // Store path: replace only the addressed lane of the captured word.
    always_comb begin
        o_wr_word = i_rmw_word;
        case (i_funct3)
            F3_B:    o_wr_word[{i_addr_lo, 3'b000} +: 8]     = i_st_data[7:0];
            F3_H:    o_wr_word[{i_addr_lo[1], 4'b0000} +: 16] = i_st_data[15:0];
            F3_W:    o_wr_word = i_st_data;
            default: o_wr_word = i_rmw_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with a single-ported, combinational-read data memory.
// One op at a time: accept in IDLE, then LOAD (read+extend), WRITE (SW) or
// RMW_RD followed by WRITE (SB/SH), finishing with a one-cycle RESP pulse.
// Faulting ops go straight to RESP without touching memory.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - op handshake (ready only in IDLE)
//   is_store, funct3      - op kind and size/sign code
//   addr, store_data      - byte address and right-aligned store source
//   resp_valid            - completion pulse; load_data/fault valid with it
//   mem_read, mem_write   - data-memory strobes (never both high)
//   mem_address           - word index addr[ADDR_W+1:2]
//   mem_write_data        - write word; mem_read_data - combinational read word
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              resp_valid,
    output logic [31:0]       load_data,
    output logic              fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e        r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_fault;
    logic [31:0]       r_load_data;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_store_data;
    logic [31:0]       r_rmw_word;

    logic              w_accept;
    logic              w_fault;
    logic [31:0]       w_load_val;
    logic [31:0]       w_merge_word;
    logic              w_unused_addr_hi;

    assign w_accept = req_valid && r_req_ready;
    assign w_fault  = op_fault(is_store, funct3, addr[1:0]);

    // Address bits above the memory window alias onto it by design.
    assign w_unused_addr_hi = ^addr[31:ADDR_W+2];

    lsu_align u_align (
        .i_funct3   (r_funct3),
        .i_addr_lo  (r_addr[1:0]),
        .i_rd_word  (mem_read_data),
        .i_rmw_word (r_rmw_word),
        .i_st_data  (r_store_data),
        .o_load_val (w_load_val),
        .o_wr_word  (w_merge_word)
    );

    // Operation FSM; every output below is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_load_data  <= 32'h0000_0000;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_store_data <= 32'h0000_0000;
            r_rmw_word   <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready  <= 1'b0;
                        r_is_store   <= is_store;
                        r_funct3     <= funct3;
                        r_addr       <= addr[ADDR_W+1:0];
                        r_store_data <= store_data;
                        r_fault      <= w_fault;
                        // Stores and faults report zero; loads overwrite in LOAD.
                        r_load_data  <= 32'h0000_0000;
                        if (w_fault) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else if (!is_store) begin
                            r_state    <= ST_LOAD;
                            r_mem_read <= 1'b1;
                        end else if (funct3 == F3_W) begin
                            r_state     <= ST_WRITE;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= ST_RMW_RD;
                            r_mem_read <= 1'b1;
                        end
                    end else begin
                        // Also raises ready on the first cycle out of reset.
                        r_req_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_load_data  <= w_load_val;
                    r_mem_read   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    r_rmw_word  <= mem_read_data;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b1;
                    r_state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_req_ready  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign fault          = r_fault;
    assign load_data      = r_load_data;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_addr[ADDR_W+1:2];
    // Write bus idles at zero for loads so it never carries stale store data.
    assign mem_write_data = r_is_store ? w_merge_word : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// ops compared against a byte-level reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        fault;
    logic        mem_read;
    logic        mem_write;
    logic [9:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = 10'd0;
    logic [31:0] bd_data = 32'h0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int rd_tot = 0, wr_tot = 0, both_tot = 0, resp_tot = 0, acc_tot = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .resp_valid     (resp_valid),
        .load_data      (load_data),
        .fault          (fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory: combinational read, write on the clock edge.
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_write) mem[mem_address] <= mem_write_data;
    end

    // Per-cycle activity counters.
    always @(posedge clk) begin
        rd_tot   += int'(mem_read);
        wr_tot   += int'(mem_write);
        both_tot += int'(mem_read && mem_write);
        resp_tot += int'(resp_valid);
        acc_tot  += int'(req_valid && req_ready);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] data);
        bd_idx  = idx[9:0];
        bd_data = data;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we   = 1'b0;
        ref_mem[idx] = data;
    endtask

    // Reference rules: legal codes, natural alignment.
    function automatic logic exp_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        if (st) begin
            if (f3 > 3'd2) return 1'b1;
        end else begin
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        end
        nbytes = 1 << f3[1:0];
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [2:0] f3);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] m, v;
        int nbytes;
        nbytes = 1 << f3[1:0];
        m = lane_mask(f3);
        v = (word >> (8 * (a % 4))) & m;
        if (f3[2] == 1'b0 && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] exp_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] word, input logic [31:0] d);
        logic [31:0] m;
        m = lane_mask(f3);
        return (word & ~(m << (8 * (a % 4)))) | ((d & m) << (8 * (a % 4)));
    endfunction

    task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input bit hold);
        int idx, guard, lat, elat, erd, ewr, rd0, wr0;
        logic ef;
        logic [31:0] eld;
        idx = int'((a >> 2) & 32'h3FF);
        ef  = exp_fault(st, f3, a);
        eld = 32'h0;
        if (ef) begin
            elat = 1; erd = 0; ewr = 0;
        end else if (!st) begin
            elat = 2; erd = 1; ewr = 0;
            eld  = exp_load(f3, a, ref_mem[idx]);
        end else if (f3 == 3'd2) begin
            elat = 2; erd = 0; ewr = 1;
        end else begin
            elat = 3; erd = 1; ewr = 1;
        end
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, ".ready_wait"}, 32'(guard < 20), 32'd1);
        rd0 = rd_tot; wr0 = wr_tot;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, ".latency"},  32'(lat), 32'(elat));
        check({tag, ".fault"},    32'(fault), 32'(ef));
        check({tag, ".load_data"}, load_data, eld);
        check({tag, ".reads"},    32'(rd_tot - rd0), 32'(erd));
        check({tag, ".writes"},   32'(wr_tot - wr0), 32'(ewr));
        check({tag, ".mem_addr"}, 32'(mem_address), 32'(idx));
        check({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
        if (st && !ef) ref_mem[idx] = exp_store(f3, a, ref_mem[idx], d);
        @(posedge clk); #1;
        check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".mem_word"},   mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int guard, acc0, resp0;
        rst_n = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'h0; store_data = 32'h0;
        #1;
        check("reset.req_ready",  32'(req_ready), 32'd0);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.strobes",    32'({mem_read, mem_write}), 32'd0);
        check("reset.fault",      32'(fault), 32'd0);
        check("reset.load_data",  load_data, 32'h0);

        for (int i = 0; i < 32; i++) bd_write(i, $urandom);
        bd_write(5,  32'h8081_8283);
        bd_write(7,  32'h1122_3344);
        bd_write(9,  32'hCAFE_F00D);
        bd_write(16, 32'h0000_0000);

        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release.req_ready", 32'(req_ready), 32'd1);

        do_op("lb_15", 1'b0, 3'd0, 32'h15, 32'h0, 1'b0);
        check("lb_15.value", load_data, 32'hFFFF_FF82);
        do_op("lhu_16", 1'b0, 3'd5, 32'h16, 32'h0, 1'b0);
        check("lhu_16.value", load_data, 32'h0000_8081);
        do_op("lh_17", 1'b0, 3'd1, 32'h17, 32'h0, 1'b0);
        check("lh_17.fault_value", 32'(fault), 32'd1);
        do_op("sb_1d", 1'b1, 3'd0, 32'h1D, 32'hAA, 1'b0);
        check("sb_1d.word7", mem[7], 32'h1122_AA44);
        do_op("sw_40", 1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF, 1'b0);
        do_op("lw_40", 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
        check("lw_40.value", load_data, 32'hDEAD_BEEF);
        do_op("lw_1040", 1'b0, 3'd2, 32'h1040, 32'h0, 1'b0);
        check("lw_1040.alias", load_data, 32'hDEAD_BEEF);

        // Reset in the write phase of a halfword store.
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd1; addr = 32'h26; store_data = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (mem_write !== 1'b1 && guard < 8) begin
            @(posedge clk); #1; guard++;
        end
        check("rst_sh.reach_write", 32'(guard < 8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_sh.mem_write", 32'(mem_write), 32'd0);
        check("rst_sh.mem_read",  32'(mem_read), 32'd0);
        check("rst_sh.resp",      32'(resp_valid), 32'd0);
        check("rst_sh.ready",     32'(req_ready), 32'd0);
        check("rst_sh.outputs",   {load_data[30:0], fault}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_sh.word9", mem[9], 32'hCAFE_F00D);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_sh.ready_after", 32'(req_ready), 32'd1);

        // Five ops with req_valid never dropped between them.
        acc0 = acc_tot; resp0 = resp_tot;
        do_op("burst0", 1'b0, 3'd2, 32'h14, 32'h0, 1'b1);
        do_op("burst1", 1'b0, 3'd4, 32'h1C, 32'h0, 1'b1);
        do_op("burst2", 1'b1, 3'd0, 32'h44, 32'h5A, 1'b1);
        do_op("burst3", 1'b1, 3'd2, 32'h48, 32'h0BAD_F00D, 1'b1);
        do_op("burst4", 1'b0, 3'd1, 32'h16, 32'h0, 1'b0);
        check("burst.accepts", 32'(acc_tot - acc0), 32'd5);
        check("burst.resps",   32'(resp_tot - resp0), 32'd5);

        for (int n = 0; n < 40; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            do_op($sformatf("rand%0d", n), st, f3, a, $urandom, 1'b0);
        end

        check("never_both_strobes", 32'(both_tot), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, data-memory word-address width (1024 words).
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  1  pipeline presents a memory op.
REQ-005 SHALL have req_ready  output  1  unit accepts an op this cycle.
REQ-006 SHALL have is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have funct3  input  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have addr  input  32  byte address.
REQ-009 SHALL have store_data  input  32  store source, right-aligned.
REQ-010 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have load_data  output  32  extended load result, valid with resp_valid.
REQ-012 SHALL have fault  output  1  misaligned/illegal op, valid with resp_valid.
REQ-013 SHALL have mem_read, mem_write  output  1 each  data-memory strobes.
REQ-014 SHALL have mem_address  output  ADDR_W  word index = addr[ADDR_W+1:2]; higher addr bits ignored.
REQ-015 SHALL have mem_write_data  output  32; mem_read_data  input  32  combinational read word.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept when req_valid&&req_ready, latching is_store, funct3, addr, store_data.
REQ-018 SHALL transition on accept: fault -> RESP; load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
REQ-019 SHALL flag fault for LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, and funct3 011/110/111 loads or >010 stores; faulting ops issue no memory strobe, load_data=0.
REQ-020 SHALL in LOAD assert mem_read, select byte addr[1:0] or half addr[1], sign-extend (LB/LH) or zero-extend (LBU/LHU), register result, go RESP.
REQ-021 SHALL in RMW_RD assert mem_read, register the word, go WRITE.
REQ-022 SHALL in WRITE assert mem_write with mem_write_data = store_data (SW) or captured word with selected byte/half lane replaced by store_data[7:0]/[15:0]; go RESP.
REQ-023 SHALL in RESP assert resp_valid for exactly one cycle, then IDLE; no back-to-back accept in RESP.
REQ-024 SHALL give accept-to-resp_valid latency 2 cycles for loads/SW, 3 for SB/SH, 1 for faults.
REQ-025 SHALL never assert mem_read and mem_write together; both 0 in IDLE and RESP.
REQ-026 SHALL hold mem_address constant from accept until leaving WRITE/LOAD.
REQ-027 SHALL hold load_data and fault stable from RESP until next accept; load_data=0 after stores.

Reset
REQ-028 SHALL on rst_n low go IDLE immediately; resp_valid, mem_read, mem_write, fault, req_ready=0, load_data=0, internal registers 0.
REQ-029 SHALL abort an in-flight op on reset; mem_write drops combinationally so no write lands at the next edge.
REQ-030 SHALL raise req_ready in the first cycle after rst_n deasserts.

Structure
REQ-031 SHALL take funct3 codes, state encoding and ADDR_W default from shared package lsu_pkg.
REQ-032 SHALL place byte/half extract and lane-merge logic in combinational sub-module lsu_align; FSM and registers in load_store_unit.

Verification
REQ-033 SHALL test memory word 5=0x8081_8283; LB addr 0x15 -> load_data 0xFFFF_FF82, resp_valid 2 cycles after accept.
REQ-034 SHALL test word 5=0x8081_8283; LHU addr 0x16 -> 0x0000_8081; LH addr 0x17 -> fault=1, no mem_read pulse.
REQ-035 SHALL test word 7=0x1122_3344; SB addr 0x1D data 0xAA -> word 7=0x1122_AA44, one mem_read then one mem_write cycle, resp_valid 3 cycles after accept.
REQ-036 SHALL test SW addr 0x40 data 0xDEAD_BEEF then LW 0x40 -> 0xDEAD_BEEF; addr 0x1040 aliases word 16.
REQ-037 SHALL test rst_n low during WRITE of SH -> target word unchanged, outputs 0, req_ready=1 after release.
REQ-038 SHALL test req_valid held high across five ops -> each accepted only in IDLE, exactly five resp_valid pulses.
